// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue
// Write-side front end for the register file's single write port.
// Results from the ALU path and the load path arrive over valid/ready
// handshakes. They are buffered in order in a small FIFO, and at most one
// register write retires per cycle through a registered output stage
// (RegWrite/addD/WB_out). Decode can see queued values through two
// forwarding lookups and a pending-write bitmap.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data   ALU result handshake
//   mem_valid/mem_ready/mem_rd/mem_data   load result handshake
//   RegWrite/addD/WB_out           registered register-file write port
//   fwd_addA/fwd_hitA/fwd_dataA    forwarding lookup A
//   fwd_addB/fwd_hitB/fwd_dataB    forwarding lookup B
//   pending                        one-hot OR of in-flight destinations
//   count                          occupied FIFO entries
module rf_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int REGW  = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [REGW-1:0]            alu_rd,
    input  logic [XLEN-1:0]            alu_data,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [REGW-1:0]            mem_rd,
    input  logic [XLEN-1:0]            mem_data,
    output logic                       RegWrite,
    output logic [REGW-1:0]            addD,
    output logic [XLEN-1:0]            WB_out,
    input  logic [REGW-1:0]            fwd_addA,
    output logic                       fwd_hitA,
    output logic [XLEN-1:0]            fwd_dataA,
    input  logic [REGW-1:0]            fwd_addB,
    output logic                       fwd_hitB,
    output logic [XLEN-1:0]            fwd_dataB,
    output logic [31:0]                pending,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [REGW-1:0] rd_q   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   free;
    logic            mem_push;
    logic            alu_push;
    logic            pop;
    logic [PW-1:0]   alu_slot;

    // Slot accounting uses start-of-cycle occupancy only; a same-edge pop
    // does not make room for an extra push.
    assign free      = CW'(DEPTH) - count;
    assign mem_ready = !rst && (free >= CW'(1));
    assign alu_ready = !rst && ((free >= CW'(2)) || ((free >= CW'(1)) && !mem_valid));

    // Writes to x0 complete the handshake but never occupy a slot.
    assign mem_push = mem_valid && mem_ready && (mem_rd != '0);
    assign alu_push = alu_valid && alu_ready && (alu_rd != '0);
    assign pop      = (count != '0);

    // The load entry is older than a same-cycle ALU entry.
    assign alu_slot = tail + PW'(mem_push);

    // Control state and the register-file output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            RegWrite <= 1'b0;
            addD     <= '0;
            WB_out   <= '0;
        end else begin
            tail  <= tail + PW'(mem_push) + PW'(alu_push);
            count <= count + CW'(mem_push) + CW'(alu_push) - CW'(pop);
            if (pop) begin
                RegWrite <= 1'b1;
                addD     <= rd_q[head];
                WB_out   <= data_q[head];
                head     <= head + PW'(1);
            end else begin
                RegWrite <= 1'b0;
            end
        end
    end

    // FIFO storage; occupancy is tracked by head/count, so no reset needed.
    always_ff @(posedge clk) begin
        if (mem_push) begin
            rd_q[tail]   <= mem_rd;
            data_q[tail] <= mem_data;
        end
        if (alu_push) begin
            rd_q[alu_slot]   <= alu_rd;
            data_q[alu_slot] <= alu_data;
        end
    end

    // Forwarding and pending bitmap. Entries are visited oldest first
    // (output stage, then FIFO head to tail) so the youngest match is the
    // last one to overwrite the result.
    always_comb begin
        logic [PW-1:0] idx;
        fwd_hitA  = 1'b0;
        fwd_dataA = '0;
        fwd_hitB  = 1'b0;
        fwd_dataB = '0;
        pending   = '0;
        idx       = '0;
        if (RegWrite) begin
            pending[addD] = 1'b1;
            if (addD == fwd_addA) begin
                fwd_hitA  = 1'b1;
                fwd_dataA = WB_out;
            end
            if (addD == fwd_addB) begin
                fwd_hitB  = 1'b1;
                fwd_dataB = WB_out;
            end
        end
        for (int j = 0; j < DEPTH; j++) begin
            idx = head + PW'(j);
            if (CW'(j) < count) begin
                pending[rd_q[idx]] = 1'b1;
                if (rd_q[idx] == fwd_addA) begin
                    fwd_hitA  = 1'b1;
                    fwd_dataA = data_q[idx];
                end
                if (rd_q[idx] == fwd_addB) begin
                    fwd_hitB  = 1'b1;
                    fwd_dataB = data_q[idx];
                end
            end
        end
        // x0 is never written, so it never forwards and is never pending.
        if (fwd_addA == '0) begin
            fwd_hitA  = 1'b0;
            fwd_dataA = '0;
        end
        if (fwd_addB == '0) begin
            fwd_hitB  = 1'b0;
            fwd_dataB = '0;
        end
        pending[0] = 1'b0;
    end

endmodule

// File: tb/tb_rf_writeback_queue.sv
module tb_rf_writeback_queue;

    logic        clk;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        RegWrite;
    logic [4:0]  addD;
    logic [31:0] WB_out;
    logic [4:0]  fwd_addA, fwd_addB;
    logic        fwd_hitA, fwd_hitB;
    logic [31:0] fwd_dataA, fwd_dataB;
    logic [31:0] pending;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    rf_writeback_queue #(.DEPTH(4), .XLEN(32), .REGW(5)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .RegWrite(RegWrite), .addD(addD), .WB_out(WB_out),
        .fwd_addA(fwd_addA), .fwd_hitA(fwd_hitA), .fwd_dataA(fwd_dataA),
        .fwd_addB(fwd_addB), .fwd_hitB(fwd_hitB), .fwd_dataB(fwd_dataB),
        .pending(pending), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an ordered list of in-flight writes plus the
    // register-file output stage.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic        m_v    = 1'b0;
    logic [4:0]  m_rd   = '0;
    logic [31:0] m_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_mrdy();
        return !rst && (q.size() < 4);
    endfunction

    function automatic logic exp_ardy();
        int fr;
        fr = 4 - q.size();
        return !rst && ((fr >= 2) || (fr >= 1 && !mem_valid));
    endfunction

    function automatic logic [32:0] mlook(input logic [4:0] a);
        if (a == 0) return 33'd0;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].rd == a) return {1'b1, q[i].data};
        if (m_v && m_rd == a) return {1'b1, m_data};
        return 33'd0;
    endfunction

    function automatic logic [31:0] mpend();
        logic [31:0] p;
        p = '0;
        foreach (q[i]) p[q[i].rd] = 1'b1;
        if (m_v) p[m_rd] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    task automatic check_all();
        logic [32:0] la, lb;
        la = mlook(fwd_addA);
        lb = mlook(fwd_addB);
        chk("count",     32'(count),     32'(q.size()));
        chk("mem_ready", 32'(mem_ready), 32'(exp_mrdy()));
        chk("alu_ready", 32'(alu_ready), 32'(exp_ardy()));
        chk("RegWrite",  32'(RegWrite),  32'(m_v));
        chk("addD",      32'(addD),      32'(m_rd));
        chk("WB_out",    WB_out,         m_data);
        chk("pending",   pending,        mpend());
        chk("fwd_hitA",  32'(fwd_hitA),  32'(la[32]));
        chk("fwd_dataA", fwd_dataA,      la[31:0]);
        chk("fwd_hitB",  32'(fwd_hitB),  32'(lb[32]));
        chk("fwd_dataB", fwd_dataB,      lb[31:0]);
    endtask

    task automatic model_edge();
        logic macc, aacc;
        ent_t e;
        if (rst) begin
            q.delete();
            m_v    = 1'b0;
            m_rd   = '0;
            m_data = '0;
        end else begin
            macc = mem_valid && exp_mrdy();
            aacc = alu_valid && exp_ardy();
            if (q.size() > 0) begin
                e      = q.pop_front();
                m_v    = 1'b1;
                m_rd   = e.rd;
                m_data = e.data;
            end else begin
                m_v = 1'b0;
            end
            if (macc && mem_rd != 0) q.push_back('{mem_rd, mem_data});
            if (aacc && alu_rd != 0) q.push_back('{alu_rd, alu_data});
        end
    endtask

    // Check at the falling edge, update the model at the rising edge,
    // then hand control back 1 time unit after the edge.
    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic drain();
        idle_inputs();
        repeat (6) cycle();
    endtask

    initial begin
        rst = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        fwd_addA = '0; fwd_addB = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset hold with queued data
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0707;
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h0909;
        fwd_addA = 5'd7; fwd_addB = 5'd9;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        chk("rst_hold_ready_m", 32'(mem_ready), 32'd0);
        chk("rst_hold_ready_a", 32'(alu_ready), 32'd0);
        cycle();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_regwrite", 32'(RegWrite), 32'd0);
        chk("rst_addD", 32'(addD), 32'd0);
        chk("rst_wb", WB_out, 32'd0);
        chk("rst_pending", pending, 32'd0);
        rst = 1'b0;
        idle_inputs();
        #1;
        chk("post_rst_mem_ready", 32'(mem_ready), 32'd1);
        chk("post_rst_alu_ready", 32'(alu_ready), 32'd1);
        cycle();

        // Single write
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
        fwd_addA = 5'd5;
        cycle();
        alu_valid = 1'b0;
        chk("single_pend_k", 32'(pending[5]), 32'd1);
        chk("single_no_rw_yet", 32'(RegWrite), 32'd0);
        cycle();
        chk("single_rw", 32'(RegWrite), 32'd1);
        chk("single_addD", 32'(addD), 32'd5);
        chk("single_wb", WB_out, 32'h1234);
        cycle();
        chk("single_pend_clr", 32'(pending[5]), 32'd0);
        drain();

        // Dual accept and order
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'hAAAA;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hBBBB;
        fwd_addA = 5'd3;
        cycle();
        idle_inputs();
        #1;
        chk("dual_hitA", 32'(fwd_hitA), 32'd1);
        chk("dual_dataA", fwd_dataA, 32'hBBBB);
        chk("dual_count", 32'(count), 32'd2);
        cycle();
        chk("dual_first_addD", 32'(addD), 32'd3);
        chk("dual_first_wb", WB_out, 32'hAAAA);
        cycle();
        chk("dual_second_wb", WB_out, 32'hBBBB);
        drain();

        // Fill and back-pressure: both ports valid every cycle
        for (int i = 0; i < 12; i++) begin
            mem_valid = 1'b1; mem_rd = 5'($urandom_range(1, 31)); mem_data = $urandom;
            alu_valid = 1'b1; alu_rd = 5'($urandom_range(1, 31)); alu_data = $urandom;
            fwd_addA = mem_rd; fwd_addB = alu_rd;
            #1;
            if (q.size() == 3) begin
                chk("fill_free1_mem", 32'(mem_ready), 32'd1);
                chk("fill_free1_alu", 32'(alu_ready), 32'd0);
            end
            cycle();
        end
        drain();

        // x0 drop
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
        fwd_addA = 5'd0;
        cycle();
        idle_inputs();
        #1;
        chk("x0_count", 32'(count), 32'd0);
        cycle();
        chk("x0_no_rw", 32'(RegWrite), 32'd0);
        chk("x0_pending", pending, 32'd0);
        chk("x0_hitA", 32'(fwd_hitA), 32'd0);
        chk("x0_dataA", fwd_dataA, 32'd0);

        // Reset mid-stream with three queued writes
        mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hA0;
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hA1;
        cycle();
        mem_rd = 5'd12; mem_data = 32'hA2;
        alu_rd = 5'd13; alu_data = 32'hA3;
        cycle();
        idle_inputs();
        #1;
        chk("mid_count3", 32'(count), 32'd3);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_count0", 32'(count), 32'd0);
        chk("mid_rw0", 32'(RegWrite), 32'd0);
        chk("mid_pend0", pending, 32'd0);
        repeat (5) cycle();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 49) == 0);
            mem_valid = ($urandom_range(0, 3) != 0);
            alu_valid = ($urandom_range(0, 3) != 0);
            mem_rd    = 5'($urandom_range(0, 7));
            alu_rd    = 5'($urandom_range(0, 7));
            mem_data  = $urandom;
            alu_data  = $urandom;
            fwd_addA  = 5'($urandom_range(0, 7));
            fwd_addB  = 5'($urandom_range(0, 7));
            cycle();
        end
        rst = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_writeback_queue.md
Name: rf_writeback_queue

Overview:
- Write-side front end for the register file's single write port (RegWrite/addD/WB_out).
- Accepts results from two producers, the ALU path and the load/memory path, over valid/ready handshakes, buffers them in order in a FIFO, and retires at most one register write per cycle.
- Exposes a pending-write bitmap and two forwarding lookups so decode can read values that are queued but not yet in the register file.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- XLEN, 32, data width.
- REGW, 5, register index width (32 architectural registers).

Ports:
- clk  in  1  system clock, all state on the rising edge.
- rst  in  1  synchronous reset, active-high.
- alu_valid  in  1  ALU result valid.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_rd  in  REGW  ALU destination register.
- alu_data  in  XLEN  ALU result.
- mem_valid  in  1  load result valid.
- mem_ready  out  1  load result accepted this cycle.
- mem_rd  in  REGW  load destination register.
- mem_data  in  XLEN  load result.
- RegWrite  out  1  register-file write enable, registered.
- addD  out  REGW  register-file write address, registered.
- WB_out  out  XLEN  register-file write data, registered.
- fwd_addA  in  REGW  forward lookup address A.
- fwd_hitA  out  1  A has an in-flight write.
- fwd_dataA  out  XLEN  youngest in-flight data for A.
- fwd_addB  in  REGW  forward lookup address B.
- fwd_hitB  out  1  B has an in-flight write.
- fwd_dataB  out  XLEN  youngest in-flight data for B.
- pending  out  32  bit i set when a write to xi is in flight; bit 0 is always 0.
- count  out  clog2(DEPTH)+1  occupied FIFO entries.

Behaviour:
- Reset (rst=1 at a rising edge):
  - Clears pointers, count, RegWrite, addD and WB_out (all 0); pending becomes 0.
  - Discards all queued writes, including when asserted mid-operation.
  - While rst=1, alu_ready=mem_ready=0.
- Ready logic is combinational from the start-of-cycle count; free = DEPTH-count.
  - mem_ready = (free>=1).
  - alu_ready = (free>=2) | (free>=1 & !mem_valid).
  - The load path has priority when only one slot is free.
- A handshake completes when valid&ready at a rising edge.
  - Both ports may complete in the same cycle. The mem entry is then enqueued first (older), and the ALU entry second.
  - rd==0: the handshake completes normally but nothing is enqueued and no slot is consumed.
- Dequeue:
  - At each rising edge, if count>0 (start of cycle), the head entry is popped into the output stage: RegWrite<=1, addD<=rd, WB_out<=data.
  - Otherwise RegWrite<=0, and addD and WB_out hold their values.
  - The register file never back-pressures; throughput is one write per cycle.
- Latency: a result accepted at edge k into an empty FIFO appears as RegWrite=1 in the cycle after edge k+1 (2 cycles).
- Count update: count_next = count + enqueues - pop. A same-edge push and pop is allowed whenever ready permitted the push.
- Pointers wrap modulo DEPTH. Full (count==DEPTH) forces both readies to 0. There is no overflow or underflow path.
- Ordering:
  - Strict FIFO order.
  - Multiple queued writes to the same rd retire in order, so the last one wins in the register file.
- Forwarding (combinational, from start-of-cycle state):
  - Searches the valid FIFO entries plus the output stage (when RegWrite=1).
  - The youngest match wins; the output stage is the oldest.
  - Address 0 never hits.
  - No hit gives fwd_hit=0 and fwd_data=0.
  - Same-cycle enqueues are not visible until the next cycle.
- pending: the OR over valid FIFO entries and the output stage (when RegWrite=1) of the one-hot rd, with bit 0 forced to 0.

Test Plan:
- Reset hold:
  - Stimulus: assert rst for 2 cycles with queued data.
  - Response: count=0, RegWrite=0, addD=0, WB_out=0, pending=0, both readies 0 during rst and 1 after rst drops with mem_valid=0.
- Single write:
  - Stimulus: alu_valid with rd=5, data=0x1234 accepted at edge k.
  - Response: pending[5]=1 from the cycle after k; RegWrite=1, addD=5, WB_out=0x1234 in the cycle after k+1; pending[5]=0 one cycle later.
- Dual accept and order:
  - Stimulus: same cycle mem rd=3/0xAAAA and alu rd=3/0xBBBB.
  - Response: the next cycle shows fwd_addA=3 with fwd_hitA=1 and fwd_dataA=0xBBBB; the output sequence is (3,0xAAAA) then (3,0xBBBB).
- Fill and back-pressure:
  - Stimulus: both ports valid every cycle, DEPTH=4.
  - Response: count never exceeds 4; when free=1, mem_ready=1 and alu_ready=0; no entry is lost or duplicated; the retire order matches the accept order.
- x0 drop:
  - Stimulus: alu rd=0, data=0xFFFF accepted.
  - Response: count unchanged, no RegWrite pulse, pending stays 0; fwd_addA=0 gives fwd_hitA=0 and fwd_dataA=0.
- Reset mid-stream:
  - Stimulus: rst asserted with count=3.
  - Response: the next cycle shows count=0, RegWrite=0 and pending=0, and none of the 3 queued writes ever appears on addD/WB_out.
